// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : switch_conditioner
//  Description : Multi-channel mechanical switch conditioner. Each raw input
//                is synchronized, debounced with a saturating-free counter,
//                and converted into a clean level plus one-clock press and
//                release pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_conditioner #(
  parameter int g_DEBOUNCE_LIMIT = 250000,
  parameter int g_NUM_SWITCHES   = 4
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic [g_NUM_SWITCHES-1:0] i_Switches,
  output logic [g_NUM_SWITCHES-1:0] o_Switches,
  output logic [g_NUM_SWITCHES-1:0] o_Pressed,
  output logic [g_NUM_SWITCHES-1:0] o_Released,
  output logic                      o_Any_Released
);

  // Counter must hold values up to g_DEBOUNCE_LIMIT-1; keep at least one bit
  // so the degenerate limit of 1 still elaborates cleanly.
  localparam int c_CNT_RAW_W = $clog2(g_DEBOUNCE_LIMIT + 1);
  localparam int c_CNT_W     = (c_CNT_RAW_W < 1) ? 1 : c_CNT_RAW_W;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(g_DEBOUNCE_LIMIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  // Two-stage synchronizer; only sync_q is ever consumed downstream.
  logic [g_NUM_SWITCHES-1:0] meta_q;
  logic [g_NUM_SWITCHES-1:0] sync_q;

  // Debounced state and registered pulse outputs.
  logic [g_NUM_SWITCHES-1:0] switches_q, switches_d;
  logic [g_NUM_SWITCHES-1:0] pressed_q,  pressed_d;
  logic [g_NUM_SWITCHES-1:0] released_q, released_d;

  // Per-channel debounce counters.
  logic [c_CNT_W-1:0] cnt_q [g_NUM_SWITCHES];
  logic [c_CNT_W-1:0] cnt_d [g_NUM_SWITCHES];

  // Per-channel decode: a transition is committed only on the edge where the
  // mismatch has already persisted for g_DEBOUNCE_LIMIT-1 prior edges, so the
  // counter never reaches g_DEBOUNCE_LIMIT and cannot wrap.
  generate
    for (genvar i = 0; i < g_NUM_SWITCHES; i++) begin : g_chan
      logic w_mismatch;
      logic w_commit;

      assign w_mismatch = sync_q[i] ^ switches_q[i];
      assign w_commit   = w_mismatch && (cnt_q[i] == c_CNT_LAST);

      assign cnt_d[i]      = (!w_mismatch || w_commit) ? c_CNT_ZERO
                                                       : (cnt_q[i] + c_CNT_ONE);
      assign switches_d[i] = w_commit ? sync_q[i] : switches_q[i];
      assign pressed_d[i]  = w_commit &&  sync_q[i];
      assign released_d[i] = w_commit && !sync_q[i];
    end : g_chan
  endgenerate

  // Synchronizer flops; cleared asynchronously so a held switch re-debounces
  // from scratch after reset.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_Switches;
      sync_q <= meta_q;
    end
  end

  // Debounce counters; reset discards any partial count.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      for (int k = 0; k < g_NUM_SWITCHES; k++) begin
        cnt_q[k] <= c_CNT_ZERO;
      end
    end else begin
      for (int k = 0; k < g_NUM_SWITCHES; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Debounced level and one-clock edge pulses.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      switches_q <= '0;
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      switches_q <= switches_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign o_Switches     = switches_q;
  assign o_Pressed      = pressed_q;
  assign o_Released     = released_q;
  assign o_Any_Released = |released_q;

endmodule : switch_conditioner
`default_nettype wire

// File: tb/tb_switch_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_conditioner
//  Description : Directed self-checking bench for switch_conditioner with a
//                debounce limit of 4 and four channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_conditioner;

  localparam int c_LIMIT = 4;
  localparam int c_NUM   = 4;

  logic             clk;
  logic             rst;
  logic [c_NUM-1:0] raw;
  logic [c_NUM-1:0] sw;
  logic [c_NUM-1:0] pressed;
  logic [c_NUM-1:0] released;
  logic             any_rel;

  int n_checks;
  int n_fail;

  switch_conditioner #(
    .g_DEBOUNCE_LIMIT(c_LIMIT),
    .g_NUM_SWITCHES  (c_NUM)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Switches    (raw),
    .o_Switches    (sw),
    .o_Pressed     (pressed),
    .o_Released    (released),
    .o_Any_Released(any_rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n edges after a raw change (edge 1 = first edge sampling it) and check
  // every output on each edge. chg_edge = 0 means no transition expected.
  task automatic run_edges(input string name, input int n, input int chg_edge,
                           input logic [3:0] sw_before, input logic [3:0] sw_after,
                           input logic [3:0] pr_mask, input logic [3:0] rel_mask);
    for (int e = 1; e <= n; e++) begin
      logic       at_chg;
      logic       past_chg;
      tick();
      at_chg   = (chg_edge != 0) && (e == chg_edge);
      past_chg = (chg_edge != 0) && (e >= chg_edge);
      check_val($sformatf("%s_sw_e%0d", name, e), 32'(sw), 32'(past_chg ? sw_after : sw_before));
      check_val($sformatf("%s_pr_e%0d", name, e), 32'(pressed), 32'(at_chg ? pr_mask : 4'b0000));
      check_val($sformatf("%s_rel_e%0d", name, e), 32'(released), 32'(at_chg ? rel_mask : 4'b0000));
      check_val($sformatf("%s_any_e%0d", name, e), 32'(any_rel), 32'(at_chg ? |rel_mask : 1'b0));
    end
  endtask

  // Bounce sequence applied one value per clock on bit 2, then held high.
  logic [8:0] bounce_seq;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    raw      = '0;

    // Reset state, observed before any clock edge.
    #2;
    check_val("rst_sw", 32'(sw), 32'h0);
    check_val("rst_pr", 32'(pressed), 32'h0);
    check_val("rst_rel", 32'(released), 32'h0);
    check_val("rst_any", 32'(any_rel), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    run_edges("idle", 3, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Bit 0 press: commit on edge 6.
    raw = 4'b0001;
    run_edges("press0", 8, 6, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

    // Bit 0 release: commit on edge 6 with any-released.
    raw = 4'b0000;
    run_edges("rel0", 8, 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);

    // Bit 1 glitch for three clocks is rejected.
    raw = 4'b0010;
    run_edges("glitch1a", 3, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    raw = 4'b0000;
    run_edges("glitch1b", 8, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Bit 2 bounce: final stable run starts at the 6th value -> pulse on edge 11.
    bounce_seq = 9'b111101101; // LSB first: 1,0,1,1,0,1,1,1,1
    for (int k = 1; k <= 14; k++) begin
      raw = (k <= 9) ? {1'b0, bounce_seq[k-1], 2'b00} : 4'b0100;
      tick();
      check_val($sformatf("bounce_sw_e%0d", k), 32'(sw), 32'(k >= 11 ? 4'b0100 : 4'b0000));
      check_val($sformatf("bounce_pr_e%0d", k), 32'(pressed), 32'(k == 11 ? 4'b0100 : 4'b0000));
      check_val($sformatf("bounce_rel_e%0d", k), 32'(released), 32'h0);
    end

    // Bits 3 and 0 rise together.
    raw = 4'b1101;
    run_edges("dual", 8, 6, 4'b0100, 4'b1101, 4'b1001, 4'b0000);

    // Three-bit release together.
    raw = 4'b0000;
    run_edges("trirel", 8, 6, 4'b1101, 4'b0000, 4'b0000, 4'b1101);

    // Establish a nonzero debounced state ahead of the mid-debounce reset.
    raw = 4'b1000;
    run_edges("pre", 8, 6, 4'b0000, 4'b1000, 4'b1000, 4'b0000);

    // Start a bit-0 press, then reset during the third mismatch cycle.
    raw = 4'b1001;
    run_edges("midrst", 5, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_sw", 32'(sw), 32'h0);
    check_val("async_pr", 32'(pressed), 32'h0);
    check_val("async_rel", 32'(released), 32'h0);
    check_val("async_any", 32'(any_rel), 32'h0);
    tick();
    check_val("inrst_pr", 32'(pressed), 32'h0);
    check_val("inrst_sw", 32'(sw), 32'h0);
    rst = 1'b0;
    // Held-high bits debounce from scratch after release.
    run_edges("postrst", 8, 6, 4'b0000, 4'b1001, 4'b1001, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_switch_conditioner
`default_nettype wire

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter g_DEBOUNCE_LIMIT, default 250000, is the number of consecutive clocks a synchronized input must differ from its debounced value before that value changes (10 ms at 25 MHz); legal range 1 to 2^24.
REQ-002 Parameter g_NUM_SWITCHES, default 4, is the number of independent switch channels; legal range 1 to 8.
REQ-003 i_Clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_Reset  input  1  asynchronous, active-high reset; one clock, asynchronous active-high reset, as fixed for this block.
REQ-005 i_Switches  input  g_NUM_SWITCHES  raw, asynchronous, bouncing switch levels; 1 = pressed.
REQ-006 o_Switches  output  g_NUM_SWITCHES  debounced switch levels.
REQ-007 o_Pressed  output  g_NUM_SWITCHES  one-clock pulse per bit on a debounced 0->1 transition.
REQ-008 o_Released  output  g_NUM_SWITCHES  one-clock pulse per bit on a debounced 1->0 transition.
REQ-009 o_Any_Released  output  1  OR of all o_Released bits, same cycle.

Function
REQ-010 Each channel SHALL pass i_Switches through a two-flop synchronizer; only the second-stage value (sync) feeds the debounce logic.
REQ-011 Each channel SHALL hold a debounce counter of ceil(log2(g_DEBOUNCE_LIMIT+1)) bits, minimum 1 bit.
REQ-012 On each edge where sync equals o_Switches, the counter SHALL be cleared to 0.
REQ-013 On each edge where sync differs from o_Switches and counter < g_DEBOUNCE_LIMIT-1, the counter SHALL increment by 1.
REQ-014 On the edge where sync differs and counter == g_DEBOUNCE_LIMIT-1, o_Switches bit SHALL take sync, counter SHALL clear to 0, and o_Pressed or o_Released SHALL assert per transition direction.
REQ-015 Latency: with the first edge that samples a new stable raw level counted as edge 1, o_Switches SHALL change on edge g_DEBOUNCE_LIMIT+2.
REQ-016 Any sync mismatch shorter than g_DEBOUNCE_LIMIT consecutive cycles SHALL leave o_Switches unchanged and produce no pulse.
REQ-017 o_Pressed and o_Released bits SHALL be registered and SHALL be high for exactly one clock per debounced transition; never both high on the same bit.
REQ-018 Channels SHALL operate independently; simultaneous transitions on several bits SHALL produce pulses on all those bits in the same cycle.
REQ-019 The counter SHALL never exceed g_DEBOUNCE_LIMIT-1 and SHALL never wrap.
REQ-020 With g_DEBOUNCE_LIMIT = 1, o_Switches SHALL follow sync with one extra register delay (edge 3).

Reset
REQ-021 While i_Reset is high, synchronizers, counters, o_Switches, o_Pressed, o_Released and o_Any_Released SHALL be 0, asynchronously and without a clock edge.
REQ-022 Reset asserted mid-debounce SHALL discard the count; a pending pulse SHALL not appear after release.
REQ-023 After reset release with a switch held at 1, that channel SHALL debounce to 1 per REQ-015 and emit one o_Pressed pulse.

Verification (g_DEBOUNCE_LIMIT = 4, g_NUM_SWITCHES = 4)
REQ-024 Reset, then raw bit0 0->1 held -> o_Switches[0] = 1 and o_Pressed = 4'b0001 for one clock on edge 6; no other outputs change.
REQ-025 Bit0 high and debounced, raw bit0 -> 0 held -> o_Released = 4'b0001 and o_Any_Released = 1 for one clock on edge 6; o_Switches = 0.
REQ-026 Raw bit1 pulses high for 3 clocks then low -> o_Switches, o_Pressed, o_Released remain 0 throughout.
REQ-027 Bounce pattern on bit2 (1,0,1,1,0,1,1,1,1 held) -> exactly one o_Pressed[2] pulse, 4 cycles plus 2 sync after the final stable run begins.
REQ-028 Raw bits 3 and 0 rise on the same clock -> o_Pressed = 4'b1001 in a single cycle.
REQ-029 i_Reset asserted between clocks during the 3rd mismatch cycle -> all outputs 0 immediately; after release with raw level held 1, o_Pressed pulse on edge 6 after release.
